// File: rtl/mul_sched.sv
// -----------------------------------------------------------------------------
// mul_sched
//
// Round-robin scheduler that shares the two 27x27 multiplier lanes among NREQ
// requesters. Each cycle it grants lane0 to the first pending requester found
// from the rr pointer. Lane1 goes either to the same requester (pair
// operation) or to the next pending single-lane requester (packing). Lane
// ownership is carried through a LAT-deep tag pipeline so that each 54-bit
// product can be routed back to the requester that owns it.
//
// Optional feature macro: MUL_SCHED_PACK_EN
//   defined   : two single-lane requesters may share one grant cycle
//   undefined : a single-lane winner uses lane0 only and lane1 stays idle
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   LAT   multiplier latency in cycles, from en to valid product (1..4)
//
// Ports:
//   clk                     clock, all logic on the rising edge
//   reset                   synchronous, active-high
//   req_vld[NREQ]           requester i has an operation pending
//   req_pair[NREQ]          1: needs both lanes, 0: needs one lane
//   req_a0/req_b0           first operand pair, requester i at [27i+26:27i]
//   req_a1/req_b1           second operand pair, used only for pair requests
//   req_gnt[NREQ]           combinational grant, same cycle as the request
//   m0_en, m1_en            lane enables to the multipliers
//   m0_in1..m1_in2          lane operands (27 bits)
//   m0_out, m1_out          lane products, valid LAT cycles after en
//   rsp_vld[NREQ]           one-cycle result pulse per requester
//   rsp_p0/rsp_p1           per-requester products, 54 bits each
//   idle                    no tags in flight
// -----------------------------------------------------------------------------
module mul_sched #(
  parameter int NREQ = 3,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ-1:0]      req_pair,
  input  logic [NREQ*27-1:0]   req_a0,
  input  logic [NREQ*27-1:0]   req_b0,
  input  logic [NREQ*27-1:0]   req_a1,
  input  logic [NREQ*27-1:0]   req_b1,
  output logic [NREQ-1:0]      req_gnt,
  output logic                 m0_en,
  output logic                 m1_en,
  output logic [26:0]          m0_in1,
  output logic [26:0]          m0_in2,
  output logic [26:0]          m1_in1,
  output logic [26:0]          m1_in2,
  input  logic [53:0]          m0_out,
  input  logic [53:0]          m1_out,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [NREQ*54-1:0]   rsp_p0,
  output logic [NREQ*54-1:0]   rsp_p1,
  output logic                 idle
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef MUL_SCHED_PACK_EN
  localparam bit PACK_EN = 1'b1;
`else
  localparam bit PACK_EN = 1'b0;
`endif

  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  // One tag per pipeline stage: which requester owns each lane.
  typedef struct packed {
    logic          v0;
    logic [IW-1:0] id0;
    logic          v1;
    logic [IW-1:0] id1;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  tag_t          tags [LAT];

  logic [26:0]   a0_arr [NREQ];
  logic [26:0]   b0_arr [NREQ];
  logic [26:0]   a1_arr [NREQ];
  logic [26:0]   b1_arr [NREQ];

  logic          found_w;
  logic          found_u;
  logic [IW-1:0] w_id;
  logic [IW-1:0] u_id;
  logic [IW:0]   scan;

  logic          pack;
  logic          g0;
  logic          g1;
  logic [IW-1:0] lane1_id;

  tag_t                   out_tag;
  logic [NREQ-1:0][53:0]  p0_arr;
  logic [NREQ-1:0][53:0]  p1_arr;

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a0_arr[i] = req_a0[27*i +: 27];
      b0_arr[i] = req_b0[27*i +: 27];
      a1_arr[i] = req_a1[27*i +: 27];
      b1_arr[i] = req_b1[27*i +: 27];
    end
  end

  // Scan from ptr upward with wraparound. The first pending requester is the
  // winner w; the second pending one is the packing candidate u.
  always_comb begin
    found_w = 1'b0;
    found_u = 1'b0;
    w_id    = '0;
    u_id    = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) begin
        scan = scan - (IW+1)'(NREQ);
      end
      if (req_vld[scan[IW-1:0]]) begin
        if (!found_w) begin
          found_w = 1'b1;
          w_id    = scan[IW-1:0];
        end else if (!found_u) begin
          found_u = 1'b1;
          u_id    = scan[IW-1:0];
        end
      end
    end
  end

  // Lane assignment. A pair candidate u is never skipped over to reach a
  // later single, so lane1 simply idles when u needs both lanes. lane1_id is
  // also the last granted id, which is what the pointer advances past.
  always_comb begin
    pack     = PACK_EN && found_w && found_u && !req_pair[w_id] && !req_pair[u_id];
    g0       = found_w && !reset;
    g1       = g0 && (req_pair[w_id] || pack);
    lane1_id = pack ? u_id : w_id;

    req_gnt = '0;
    m0_en   = g0;
    m1_en   = g1;
    m0_in1  = '0;
    m0_in2  = '0;
    m1_in1  = '0;
    m1_in2  = '0;

    if (g0) begin
      req_gnt[w_id] = 1'b1;
      m0_in1        = a0_arr[w_id];
      m0_in2        = b0_arr[w_id];
      if (req_pair[w_id]) begin
        m1_in1 = a1_arr[w_id];
        m1_in2 = b1_arr[w_id];
      end else if (pack) begin
        req_gnt[u_id] = 1'b1;
        m1_in1        = a0_arr[u_id];
        m1_in2        = b0_arr[u_id];
      end
    end

    if (g0) begin
      ptr_nxt = (lane1_id == LAST_ID) ? '0 : lane1_id + 1'b1;
    end else begin
      ptr_nxt = ptr;
    end
  end

  // Pointer and tag pipeline. Tags shift every cycle because the multipliers
  // cannot stall; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      for (int i = 0; i < LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      ptr     <= ptr_nxt;
      tags[0] <= {g0, w_id, g1, lane1_id};
      for (int i = 1; i < LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Route products from the last tag stage. A lane1 tag with the same owner
  // as lane0 is the second half of a pair; otherwise it is a packed single
  // and its product lands in that requester's p0 slot.
  always_comb begin
    out_tag = tags[LAT-1];
    rsp_vld = '0;
    p0_arr  = '0;
    p1_arr  = '0;
    if (!reset && out_tag.v0) begin
      rsp_vld[out_tag.id0] = 1'b1;
      p0_arr[out_tag.id0]  = m0_out;
      if (out_tag.v1) begin
        if (out_tag.id1 == out_tag.id0) begin
          p1_arr[out_tag.id0] = m1_out;
        end else begin
          rsp_vld[out_tag.id1] = 1'b1;
          p0_arr[out_tag.id1]  = m1_out;
        end
      end
    end
  end

  assign rsp_p0 = p0_arr;
  assign rsp_p1 = p1_arr;

  // Idle when no stage holds a valid lane owner.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (tags[i].v0 || tags[i].v1) begin
        idle = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// -----------------------------------------------------------------------------
// tb_mul_sched
//
// Directed bench for mul_sched with NREQ=3, LAT=2. A behavioural two-lane
// multiplier returns products LAT cycles after en (junk when not enabled).
// Stimulus pushes hand-computed responses into a queue; a monitor pops and
// compares whenever rsp_vld is non-zero. Pack-dependent expectations follow
// MUL_SCHED_PACK_EN.
// -----------------------------------------------------------------------------
module tb_mul_sched;

  localparam int NREQ = 3;
  localparam int LAT  = 2;
  localparam logic [53:0] JUNK = 54'h2AAAAAAAAAAAAA;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_pair;
  logic [NREQ*27-1:0]   req_a0;
  logic [NREQ*27-1:0]   req_b0;
  logic [NREQ*27-1:0]   req_a1;
  logic [NREQ*27-1:0]   req_b1;
  logic [NREQ-1:0]      req_gnt;
  logic                 m0_en;
  logic                 m1_en;
  logic [26:0]          m0_in1;
  logic [26:0]          m0_in2;
  logic [26:0]          m1_in1;
  logic [26:0]          m1_in2;
  logic [53:0]          m0_out;
  logic [53:0]          m1_out;
  logic [NREQ-1:0]      rsp_vld;
  logic [NREQ*54-1:0]   rsp_p0;
  logic [NREQ*54-1:0]   rsp_p1;
  logic                 idle;

  mul_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (req_vld),
    .req_pair (req_pair),
    .req_a0   (req_a0),
    .req_b0   (req_b0),
    .req_a1   (req_a1),
    .req_b1   (req_b1),
    .req_gnt  (req_gnt),
    .m0_en    (m0_en),
    .m1_en    (m1_en),
    .m0_in1   (m0_in1),
    .m0_in2   (m0_in2),
    .m1_in1   (m1_in1),
    .m1_in2   (m1_in2),
    .m0_out   (m0_out),
    .m1_out   (m1_out),
    .rsp_vld  (rsp_vld),
    .rsp_p0   (rsp_p0),
    .rsp_p1   (rsp_p1),
    .idle     (idle)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier lanes with fixed latency
  logic [53:0] pipe0 [LAT];
  logic [53:0] pipe1 [LAT];
  always @(posedge clk) begin
    pipe0[0] <= m0_en ? ({27'd0, m0_in1} * {27'd0, m0_in2}) : JUNK;
    pipe1[0] <= m1_en ? ({27'd0, m1_in1} * {27'd0, m1_in2}) : JUNK;
    for (int i = 1; i < LAT; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign m0_out = pipe0[LAT-1];
  assign m1_out = pipe1[LAT-1];

  // Scoreboard
  typedef struct {
    int                  cyc;
    logic [NREQ-1:0]     vld;
    logic [NREQ*54-1:0]  p0;
    logic [NREQ*54-1:0]  p1;
  } exp_t;

  exp_t sbq [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string nm, input logic [161:0] act, input logic [161:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_grant(input string nm, input logic [NREQ-1:0] g, input logic e0, input logic e1);
    checkOutput({nm, "_gnt"}, 162'(req_gnt), 162'(g));
    checkOutput({nm, "_m0en"}, 162'(m0_en), 162'(e0));
    checkOutput({nm, "_m1en"}, 162'(m1_en), 162'(e1));
  endtask

  function automatic logic [NREQ*54-1:0] slot(input int id, input logic [53:0] v);
    logic [NREQ*54-1:0] r;
    r = '0;
    r[54*id +: 54] = v;
    return r;
  endfunction

  task automatic push_rsp(input int c, input logic [NREQ-1:0] v,
                          input logic [NREQ*54-1:0] p0, input logic [NREQ*54-1:0] p1);
    exp_t e;
    e.cyc = c;
    e.vld = v;
    e.p0  = p0;
    e.p1  = p1;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input int i, input logic pair,
                               input logic [26:0] a0, input logic [26:0] b0,
                               input logic [26:0] a1, input logic [26:0] b1);
    req_vld[i]           = 1'b1;
    req_pair[i]          = pair;
    req_a0[27*i +: 27]   = a0;
    req_b0[27*i +: 27]   = b0;
    req_a1[27*i +: 27]   = a1;
    req_b1[27*i +: 27]   = b1;
  endtask

  // Monitor: samples 2 time units after the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL rsp_missing: expected rsp_vld %0h at cycle %0d did not arrive", sbq[0].vld, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (rsp_vld !== '0) begin
        if (sbq.size() == 0) begin
          checkOutput("rsp_unexpected", 162'(rsp_vld), 162'(0));
        end else begin
          e = sbq.pop_front();
          checkOutput("rsp_cycle", 162'(cyc), 162'(e.cyc));
          checkOutput("rsp_vld", 162'(rsp_vld), 162'(e.vld));
          checkOutput("rsp_p0", rsp_p0, e.p0);
          checkOutput("rsp_p1", rsp_p1, e.p1);
        end
      end
    end
  end

  // Hand-computed products for the held-pair round-robin test
  logic [53:0] rr_p0 [NREQ];
  logic [53:0] rr_p1 [NREQ];
  initial begin
    rr_p0 = '{54'd2, 54'd4, 54'd6};
    rr_p1 = '{54'd6, 54'd9, 54'd12};
  end

  // Directed stimulus
  initial begin
    int t;
    int id;
    reset    = 1'b1;
    req_vld  = '0;
    req_pair = '0;
    req_a0   = '0;
    req_b0   = '0;
    req_a1   = '0;
    req_b1   = '0;

    // Reset state: grants suppressed even with a pending request
    @(negedge clk);
    applyStimulus(0, 1'b1, 27'd3, 27'd5, 27'd7, 27'd11);
    #1;
    check_grant("in_reset", 3'b000, 1'b0, 1'b0);
    checkOutput("rst_idle", 162'(idle), 162'(1));
    checkOutput("rst_rsp_vld", 162'(rsp_vld), 162'(0));

    // Pair request on requester 0
    @(negedge clk);
    reset = 1'b0;
    #1;
    t = cyc;
    check_grant("pair", 3'b001, 1'b1, 1'b1);
    checkOutput("pair_m0_in1", 162'(m0_in1), 162'(3));
    checkOutput("pair_m0_in2", 162'(m0_in2), 162'(5));
    checkOutput("pair_m1_in1", 162'(m1_in1), 162'(7));
    checkOutput("pair_m1_in2", 162'(m1_in2), 162'(11));
    push_rsp(t + 2, 3'b001, slot(0, 54'd15), slot(0, 54'd77));
    @(negedge clk);
    req_vld[0] = 1'b0;
    #1;
    check_grant("pair_off", 3'b000, 1'b0, 1'b0);
    checkOutput("idle_t1", 162'(idle), 162'(0));
    @(negedge clk);
    #1;
    checkOutput("idle_t2", 162'(idle), 162'(0));
    @(negedge clk);
    #1;
    checkOutput("idle_t3", 162'(idle), 162'(1));

    // Reset to bring ptr back to 0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All three held as pairs: grants rotate 0,1,2,0,1,2
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 1'b1, 27'(i + 1), 27'd2, 27'(i + 2), 27'd3);
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      id = k % NREQ;
      check_grant("rr", 3'(1 << id), 1'b1, 1'b1);
      push_rsp(cyc + 2, 3'(1 << id), slot(id, rr_p0[id]), slot(id, rr_p1[id]));
    end
    @(negedge clk);
    req_vld = '0;
    #1;
    check_grant("rr_off", 3'b000, 1'b0, 1'b0);

    // Move ptr to 1 with a lone single on requester 0
    @(negedge clk);
    applyStimulus(0, 1'b0, 27'd2, 27'd3, 27'd0, 27'd0);
    #1;
    check_grant("ptr_set", 3'b001, 1'b1, 1'b0);
    push_rsp(cyc + 2, 3'b001, slot(0, 54'd6), '0);

    // Two singles, req1 4x6 and req2 9x9, with ptr=1
    @(negedge clk);
    req_vld[0] = 1'b0;
    applyStimulus(1, 1'b0, 27'd4, 27'd6, 27'd0, 27'd0);
    applyStimulus(2, 1'b0, 27'd9, 27'd9, 27'd0, 27'd0);
    #1;
`ifdef MUL_SCHED_PACK_EN
    check_grant("pack", 3'b110, 1'b1, 1'b1);
    checkOutput("pack_m0_in1", 162'(m0_in1), 162'(4));
    checkOutput("pack_m1_in1", 162'(m1_in1), 162'(9));
    checkOutput("pack_m1_in2", 162'(m1_in2), 162'(9));
    push_rsp(cyc + 2, 3'b110, slot(1, 54'd24) | slot(2, 54'd81), '0);
    @(negedge clk);
    req_vld = '0;
    #1;
    check_grant("pack_off", 3'b000, 1'b0, 1'b0);
`else
    check_grant("nopack_a", 3'b010, 1'b1, 1'b0);
    push_rsp(cyc + 2, 3'b010, slot(1, 54'd24), '0);
    @(negedge clk);
    req_vld[1] = 1'b0;
    #1;
    check_grant("nopack_b", 3'b100, 1'b1, 1'b0);
    push_rsp(cyc + 2, 3'b100, slot(2, 54'd81), '0);
    @(negedge clk);
    req_vld = '0;
    #1;
    check_grant("nopack_off", 3'b000, 1'b0, 1'b0);
`endif

    // ptr=0: req0 single then req1 pair; the pair is never packed behind
    @(negedge clk);
    applyStimulus(0, 1'b0, 27'd5, 27'd7, 27'd0, 27'd0);
    applyStimulus(1, 1'b1, 27'd2, 27'd8, 27'd3, 27'd9);
    #1;
    check_grant("single_first", 3'b001, 1'b1, 1'b0);
    push_rsp(cyc + 2, 3'b001, slot(0, 54'd35), '0);
    @(negedge clk);
    req_vld[0] = 1'b0;
    #1;
    check_grant("pair_next", 3'b010, 1'b1, 1'b1);
    push_rsp(cyc + 2, 3'b010, slot(1, 54'd16), slot(1, 54'd27));
    @(negedge clk);
    req_vld = '0;
    #1;
    check_grant("sp_off", 3'b000, 1'b0, 1'b0);

    // Grant req0, then reset the next cycle: the response must vanish
    @(negedge clk);
    applyStimulus(0, 1'b0, 27'd10, 27'd10, 27'd0, 27'd0);
    #1;
    check_grant("pre_reset", 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    req_vld = '0;
    reset   = 1'b1;
    #1;
    check_grant("during_reset", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("idle_after_rst", 162'(idle), 162'(1));

    // All pending after reset: ptr=0 so requester 0 wins
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 1'b1, 27'd12, 27'd12, 27'd100, 27'd100);
    end
    #1;
    check_grant("after_rst", 3'b001, 1'b1, 1'b1);
    push_rsp(cyc + 2, 3'b001, slot(0, 54'd144), slot(0, 54'd10000));
    @(negedge clk);
    req_vld = '0;

    // Drain
    repeat (5) @(negedge clk);
    #3;
    checkOutput("sb_empty", 162'(sbq.size()), 162'(0));
    checkOutput("final_idle", 162'(idle), 162'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
